// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-line instruction cache in front of the memory IO IC port
// Hits answer in one cycle; misses issue a single word fetch and fill from the returned word.
module icache #(
  parameter  int ADR_W = 17,
  parameter  int LINES = 64,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             if_en_i,
  input  logic [ADR_W-1:0] if_pc_i,
  output logic             if_en_o,
  output logic [31:0]      if_ins_o,
  output logic             mem_en_o,
  output logic [ADR_W-1:0] mem_pc_o,
  input  logic             mem_en_i,
  input  logic [31:0]      mem_ins_i,
  input  logic             br_flag,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o
);

  localparam int TAG_W = ADR_W - IDX_W - 2;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t           state;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req_hit;
  logic             pc_unused;

  assign req_idx   = if_pc_i[IDX_W+1:2];
  assign req_tag   = if_pc_i[ADR_W-1:IDX_W+2];
  assign req_hit   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign pc_unused = ^if_pc_i[1:0];

  // Tag/data arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (en && state == S_MISS && mem_en_i) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= mem_ins_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      valid      <= '0;
      miss_idx   <= '0;
      miss_tag   <= '0;
      if_en_o    <= 1'b0;
      if_ins_o   <= '0;
      mem_en_o   <= 1'b0;
      mem_pc_o   <= '0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (en) begin
      if_en_o  <= 1'b0;
      mem_en_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_en_i && !br_flag) begin
            if (req_hit) begin
              if_en_o  <= 1'b1;
              if_ins_o <= data_mem[req_idx];
              if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
            end else begin
              mem_en_o <= 1'b1;
              mem_pc_o <= {if_pc_i[ADR_W-1:2], 2'b00};
              miss_idx <= req_idx;
              miss_tag <= req_tag;
              if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
              state    <= S_MISS;
            end
          end
        end
        S_MISS: begin
          // A return coinciding with a flush still fills: the word is right for its address.
          if (mem_en_i) begin
            valid[miss_idx] <= 1'b1;
            if (!br_flag) begin
              if_en_o  <= 1'b1;
              if_ins_o <= mem_ins_i;
            end
            state <= S_IDLE;
          end else if (br_flag) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache against a line-array reference model
module tb_icache;
  localparam int ADR_W = 17;
  localparam int LINES = 64;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b1;
  logic             if_en_i = 1'b0;
  logic [ADR_W-1:0] if_pc_i = '0;
  logic             if_en_o;
  logic [31:0]      if_ins_o;
  logic             mem_en_o;
  logic [ADR_W-1:0] mem_pc_o;
  logic             mem_en_i = 1'b0;
  logic [31:0]      mem_ins_i = '0;
  logic             br_flag = 1'b0;
  logic [31:0]      hit_cnt_o;
  logic [31:0]      miss_cnt_o;

  icache #(.ADR_W(ADR_W), .LINES(LINES)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .if_en_i(if_en_i), .if_pc_i(if_pc_i),
    .if_en_o(if_en_o), .if_ins_o(if_ins_o),
    .mem_en_o(mem_en_o), .mem_pc_o(mem_pc_o),
    .mem_en_i(mem_en_i), .mem_ins_i(mem_ins_i),
    .br_flag(br_flag),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  bit          mv [LINES];
  int unsigned mt [LINES];
  logic [31:0] md [LINES];
  logic [31:0] hits = 0;
  logic [31:0] misses = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    hits = 0;
    misses = 0;
  endtask

  // Backing memory contents: fixed per word address.
  function automatic logic [31:0] mem_word(input logic [ADR_W-1:0] pc);
    int unsigned a;
    a = int'(pc) & ~3;
    case (a)
      32'h100: return 32'h0000_0013;
      32'h200: return 32'h00A0_0093;
      32'h400: return 32'h1234_5678;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endcase
  endfunction

  // mode 0: normal return, 1: flush alone while waiting, 2: flush together with return
  task automatic fetch(input logic [ADR_W-1:0] pc, input int lat, input int mode);
    int unsigned idx, tag;
    logic [31:0] w;
    idx = (int'(pc) / 4) % LINES;
    tag = int'(pc) / (4 * LINES);
    w   = mem_word(pc);
    if_en_i = 1'b1;
    if_pc_i = pc;
    cyc();
    if_en_i = 1'b0;
    if (mv[idx] && mt[idx] == tag) begin
      hits++;
      chk("hit_en", {31'd0, if_en_o}, 32'd1);
      chk("hit_ins", if_ins_o, md[idx]);
      chk("hit_no_mem", {31'd0, mem_en_o}, 32'd0);
      chk("hit_cnt", hit_cnt_o, hits);
    end else begin
      misses++;
      chk("miss_mem_en", {31'd0, mem_en_o}, 32'd1);
      chk("miss_mem_pc", {15'd0, mem_pc_o}, int'(pc) & ~3);
      chk("miss_no_if", {31'd0, if_en_o}, 32'd0);
      chk("miss_cnt", miss_cnt_o, misses);
      for (int i = 0; i < lat; i++) begin
        cyc();
        chk("wait_quiet", {30'd0, if_en_o, mem_en_o}, 32'd0);
      end
      if (mode == 1) begin
        br_flag = 1'b1;
        cyc();
        br_flag = 1'b0;
        chk("flush_no_if", {31'd0, if_en_o}, 32'd0);
        cyc();
        chk("flush_no_if2", {31'd0, if_en_o}, 32'd0);
      end else begin
        mem_en_i  = 1'b1;
        mem_ins_i = w;
        br_flag   = (mode == 2);
        cyc();
        mem_en_i = 1'b0;
        br_flag  = 1'b0;
        mv[idx] = 1'b1;
        mt[idx] = tag;
        md[idx] = w;
        if (mode == 2) begin
          chk("flushret_no_if", {31'd0, if_en_o}, 32'd0);
        end else begin
          chk("fill_en", {31'd0, if_en_o}, 32'd1);
          chk("fill_ins", if_ins_o, w);
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    chk("rst_if_en", {31'd0, if_en_o}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en_o}, 32'd0);
    chk("rst_mem_pc", {15'd0, mem_pc_o}, 32'd0);
    chk("rst_ins", if_ins_o, 32'd0);
    chk("rst_cnts", hit_cnt_o | miss_cnt_o, 32'd0);
    rst_n = 1'b1;
    cyc();

    // miss then fill, hit, conflict eviction
    fetch(17'h00100, 2, 0);
    chk("t1_miss_cnt", miss_cnt_o, 32'd1);
    fetch(17'h00100, 0, 0);
    chk("t2_hit_cnt", hit_cnt_o, 32'd1);
    fetch(17'h00200, 1, 0);
    fetch(17'h00100, 0, 0);
    chk("t3_miss_cnt", miss_cnt_o, 32'd3);

    // en=0 freezes a pending pulse
    fetch(17'h00100, 0, 0);
    en = 1'b0;
    cyc();
    cyc();
    chk("en_hold", {31'd0, if_en_o}, 32'd1);
    en = 1'b1;
    cyc();
    chk("en_clear", {31'd0, if_en_o}, 32'd0);

    // flush during miss, then next request is accepted
    fetch(17'h00300, 1, 1);
    fetch(17'h00104, 0, 0);

    // flush coincident with return still fills
    fetch(17'h00400, 0, 2);
    fetch(17'h00400, 0, 0);
    chk("t5_hit_ins", if_ins_o, 32'h1234_5678);

    // flush with request in IDLE drops it; stray return in IDLE is ignored
    if_en_i = 1'b1;
    if_pc_i = 17'h00700;
    br_flag = 1'b1;
    mem_en_i = 1'b1;
    mem_ins_i = 32'hDEAD_BEEF;
    cyc();
    if_en_i = 1'b0;
    br_flag = 1'b0;
    mem_en_i = 1'b0;
    chk("drop_quiet", {30'd0, if_en_o, mem_en_o}, 32'd0);
    chk("drop_hits", hit_cnt_o, hits);
    chk("drop_misses", miss_cnt_o, misses);

    // async reset mid-miss
    if_en_i = 1'b1;
    if_pc_i = 17'h00500;
    cyc();
    if_en_i = 1'b0;
    chk("ar_mem_en", {31'd0, mem_en_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_outs", {30'd0, if_en_o, mem_en_o}, 32'd0);
    chk("ar_pc", {15'd0, mem_pc_o}, 32'd0);
    chk("ar_ins", if_ins_o, 32'd0);
    chk("ar_cnts", hit_cnt_o | miss_cnt_o, 32'd0);
    cyc();
    rst_n = 1'b1;
    model_reset();
    mem_en_i = 1'b1;
    mem_ins_i = 32'hCAFE_F00D;
    cyc();
    mem_en_i = 1'b0;
    chk("ar_late_ignored", {31'd0, if_en_o}, 32'd0);
    fetch(17'h00100, 1, 0);
    chk("ar_remiss", miss_cnt_o, 32'd1);

    // randomized fetch stream over a conflicting address set
    for (int n = 0; n < 300; n++) begin
      logic [ADR_W-1:0] pc;
      int m;
      pc = ADR_W'(($urandom_range(0, 127) << 2) | ($urandom_range(0, 3) << 12)
                  | $urandom_range(0, 3));
      m  = $urandom_range(0, 9);
      fetch(pc, $urandom_range(0, 3), (m == 8) ? 1 : (m == 9) ? 2 : 0);
      if ($urandom_range(0, 3) == 0) cyc();
    end
    chk("rand_hits", hit_cnt_o, hits);
    chk("rand_misses", miss_cnt_o, misses);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, word-line instruction cache between the instruction fetch unit and the memory IO controller. It answers fetch hits in one cycle and turns misses into single 4-byte fetch requests on the controller's IC port. It fills from the returned word and abandons in-flight fetches on branch flush, matching the controller's own flush behaviour. Hit and miss counters are exposed for performance bring-up.

## Interface
Parameters:
- `ADR_W`, 17: RAM byte-address width; equals `RAM_ADR_W`.
- `LINES`, 64: number of one-word lines; power of two, ≥2.
- `IDX_W`, `$clog2(LINES)`: index width; derived, not overridden.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: global enable. When 0, every register holds, outputs included.
- `if_en_i`  in  1: fetch request strobe from IF, one cycle.
- `if_pc_i`  in  ADR_W: fetch byte address; word-aligned, so bits [1:0] are ignored.
- `if_en_o`  out  1: instruction-valid pulse to IF.
- `if_ins_o`  out  32: instruction word; valid while `if_en_o`=1.
- `mem_en_o`  out  1: miss request pulse to the memory IO controller IC port.
- `mem_pc_o`  out  ADR_W: miss address, word-aligned with [1:0]=0.
- `mem_en_i`  in  1: word-returned pulse from the memory IO controller.
- `mem_ins_i`  in  32: returned word, little-endian; valid with `mem_en_i`.
- `br_flag`  in  1: branch flush.
- `hit_cnt_o`  out  32: count of hits serviced.
- `miss_cnt_o`  out  32: count of misses issued.

## Operation
- Address split:
  - index = `pc[IDX_W+1:2]`
  - tag = `pc[ADR_W-1:IDX_W+2]`
- Per-line storage: valid bit, tag, 32-bit data.
- States: IDLE and MISS.
- IDLE, `if_en_i`=1, `br_flag`=0:
  - Hit (line valid and tags equal): register `if_en_o`=1 and `if_ins_o`=line data. `hit_cnt_o` increments. Stay in IDLE.
  - Miss: register `mem_en_o`=1 and `mem_pc_o`={`pc[ADR_W-1:2]`,2'b00}. Latch the index and tag. `miss_cnt_o` increments. Go to MISS.
- MISS:
  - `if_en_i` is ignored. IF keeps at most one request outstanding.
  - On `mem_en_i`=1 with `br_flag`=0: write line (valid=1, latched tag, `mem_ins_i`). Register `if_en_o`=1 and `if_ins_o`=`mem_ins_i`. Go to IDLE.
  - On `br_flag`=1 with `mem_en_i`=0: go to IDLE with no fill and no response. The controller discards the fetch itself, so no `mem_en_i` follows.
  - On `br_flag`=1 and `mem_en_i`=1 in the same cycle: fill the line, since the data is correct for that address. Suppress `if_en_o` and go to IDLE.
- `br_flag`=1 in IDLE together with `if_en_i`: the request is dropped. No lookup, no counter change, no outputs.
- `mem_en_i` while in IDLE is ignored.
- The cache is never invalidated except by reset. Self-modifying code is unsupported.
- Counters saturate at 0xFFFFFFFF.

## Timing
- Reset values:
  - `if_en_o`=0, `if_ins_o`=0, `mem_en_o`=0, `mem_pc_o`=0
  - `hit_cnt_o`=0, `miss_cnt_o`=0
  - all valid bits 0, state IDLE
- Reset acts immediately when `rst_n` falls, including in the middle of MISS. A word the controller returns after reset is ignored because the state is IDLE.
- `if_en_o` and `mem_en_o` are single-cycle pulses. Each is cleared in the next enabled cycle.
- Hit latency: request in cycle t, `if_en_o` in t+1.
- Miss: request in cycle t, `mem_en_o` in t+1. If `mem_en_i` arrives in cycle m, `if_en_o` is asserted in m+1.
- Back-to-back: a new `if_en_i` is accepted in the cycle `if_en_o` is high, since the state is already IDLE.
- With `en`=0, nothing advances. A pending pulse stays high until the next enabled edge.

## Test plan
- Miss then fill:
  - Stimulus: reset, fetch 0x00100.
  - Response: `mem_en_o`=1 with `mem_pc_o`=0x00100 one cycle later. Drive `mem_en_i` with 0x00000013; `if_en_o`=1 and `if_ins_o`=0x00000013 the next cycle; `miss_cnt_o`=1.
- Hit:
  - Stimulus: fetch 0x00100 again.
  - Response: `if_en_o`=1 with 0x00000013 after one cycle; no `mem_en_o`; `hit_cnt_o`=1.
- Conflict eviction (LINES=64):
  - Stimulus: fetch 0x00200, return 0x00A00093, then fetch 0x00100.
  - Response: both fetches miss (`miss_cnt_o`=3). 0x00100 returns the newly filled word.
- Flush in MISS:
  - Stimulus: fetch 0x00300 (miss); pulse `br_flag` two cycles later.
  - Response: no `if_en_o`. The next `if_en_i` for 0x00104 is accepted in IDLE and issues `mem_en_o`.
- Flush coincident with return:
  - Stimulus: `br_flag` and `mem_en_i` (0x12345678) in the same cycle for 0x00400.
  - Response: `if_en_o` stays 0. A later fetch of 0x00400 hits with 0x12345678.
- Async reset in MISS:
  - Stimulus: drop `rst_n` between `mem_en_o` and `mem_en_i`.
  - Response: all outputs read 0 before the next clock edge. A late `mem_en_i` is ignored, and fetching 0x00100 misses again.
